// File: rtl/uart_cmd_sequencer.sv
// Command sequencer: assembles CMD/ADDR[/DATA] frames from received UART bytes, issues one
// APB transfer and returns a one-byte response. Define UART_CMD_NAK_EN to NAK aborted frames.
module uart_cmd_sequencer #(
    parameter logic [7:0]  CMD_WR         = 8'hA5,
    parameter logic [7:0]  CMD_RD         = 8'h5A,
    parameter logic [7:0]  RSP_ACK        = 8'h4B,
    parameter logic [7:0]  RSP_NAK        = 8'h4E,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_err,
    output logic       apb_req,
    output logic       apb_write,
    output logic [7:0] apb_addr,
    output logic [7:0] apb_wdata,
    input  logic       apb_done,
    input  logic [7:0] apb_rdata,
    input  logic       apb_slverr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_busy,
    output logic       cmd_err,
    output logic       busy,
    output logic [2:0] fsm_state
);
    // Handshakes: rx_valid, frame_err, apb_done, tx_valid and cmd_err are one-cycle pulses with
    // no back-pressure; apb_req is a level held (fields frozen) until apb_done; tx_valid only
    // fires after tx_busy was seen low, so the transmitter is never loaded while busy.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_ADDR  = 3'd1,
        GET_DATA  = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        RESPOND   = 3'd5,
        ABORT     = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        write_q;
    logic [15:0] tmo_cnt;
    logic [7:0]  rsp_q;
    logic        tx_fire;
    logic        frame_state;
    logic        tmo_hit;
    logic        byte_ok;
    logic        cmd_ok;

    assign frame_state = (state == GET_ADDR) || (state == GET_DATA);
    assign tmo_hit     = (tmo_cnt == TIMEOUT_CYCLES - 16'd1);
    assign byte_ok     = rx_valid && !frame_err;
    assign cmd_ok      = (rx_data == CMD_WR) || (rx_data == CMD_RD);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_valid) next_state = cmd_ok ? GET_ADDR : ABORT;
            end
            GET_ADDR: begin
                if (frame_err)     next_state = ABORT;
                else if (rx_valid) next_state = write_q ? GET_DATA : ISSUE;
                else if (tmo_hit)  next_state = ABORT;
            end
            GET_DATA: begin
                if (frame_err)     next_state = ABORT;
                else if (rx_valid) next_state = ISSUE;
                else if (tmo_hit)  next_state = ABORT;
            end
            ISSUE:     next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (apb_done) next_state = RESPOND;
            end
            RESPOND: begin
                if (tx_valid) next_state = IDLE;
            end
            ABORT: begin
`ifdef UART_CMD_NAK_EN
                next_state = RESPOND;
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Fire straight off apb_done when the transmitter is free, giving one-cycle turnaround.
    always_comb begin
        tx_fire = 1'b0;
        if (state == WAIT_DONE && apb_done && !tx_busy) tx_fire = 1'b1;
        if (state == RESPOND && !tx_valid && !tx_busy)  tx_fire = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            tmo_cnt   <= 16'd0;
            apb_addr  <= 8'd0;
            apb_wdata <= 8'd0;
            apb_req   <= 1'b0;
            rsp_q     <= 8'd0;
            tx_valid  <= 1'b0;
        end else begin
            state    <= next_state;
            tx_valid <= tx_fire;
            if (frame_state && !rx_valid) tmo_cnt <= tmo_cnt + 16'd1;
            else                          tmo_cnt <= 16'd0;
            if (state == IDLE && rx_valid && cmd_ok) write_q <= (rx_data == CMD_WR);
            if (state == GET_ADDR && byte_ok) apb_addr  <= rx_data;
            if (state == GET_DATA && byte_ok) apb_wdata <= rx_data;
            if (next_state == ISSUE)                  apb_req <= 1'b1;
            else if (state == WAIT_DONE && apb_done)  apb_req <= 1'b0;
            if (state == WAIT_DONE && apb_done) begin
                if (apb_slverr)   rsp_q <= RSP_NAK;
                else if (write_q) rsp_q <= RSP_ACK;
                else              rsp_q <= apb_rdata;
            end
`ifdef UART_CMD_NAK_EN
            else if (state == ABORT) rsp_q <= RSP_NAK;
`endif
        end
    end

    assign apb_write = write_q;
    assign tx_data   = rsp_q;
    assign cmd_err   = (state == ABORT);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: frame vectors from a table, scoreboard on transmitted bytes,
// plus hand sequences for timeout, frame error and reset during a transfer.
module tb_uart_cmd_sequencer;
    localparam int TMO = 100;
`ifdef UART_CMD_NAK_EN
    localparam bit NAK_EN = 1'b1;
`else
    localparam bit NAK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       apb_req;
    logic       apb_write;
    logic [7:0] apb_addr;
    logic [7:0] apb_wdata;
    logic       apb_done;
    logic [7:0] apb_rdata;
    logic       apb_slverr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_busy;
    logic       cmd_err;
    logic       busy;
    logic [2:0] fsm_state;

    int n_cmp = 0;
    int n_fail = 0;
    logic req_ok = 1'b0;
    logic err_ok = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       slverr;
        int         gap;
        int         dly;
        int         busy_cyc;
        logic       exp_req;
        logic       exp_write;
        logic [7:0] exp_rsp;
    } vec_t;

    vec_t vecs[8];

    uart_cmd_sequencer #(.TIMEOUT_CYCLES(16'(TMO))) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .apb_req(apb_req), .apb_write(apb_write), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_done(apb_done), .apb_rdata(apb_rdata), .apb_slverr(apb_slverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .cmd_err(cmd_err), .busy(busy), .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard and protocol monitors
    always @(negedge clk) begin
        check("spurious_req", 32'(apb_req & ~req_ok), 0);
        check("spurious_cmd_err", 32'(cmd_err & ~err_ok), 0);
        check("tx_while_busy", 32'(tx_valid & tx_busy), 0);
        if (tx_valid) begin
            check("tx_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (6) @(negedge clk);
        check({name, "_tx_count"}, 32'(exp_q.size()), 0);
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v);
        if (!v.exp_req) begin
            err_ok = 1'b1;
            if (NAK_EN) exp_q.push_back(v.exp_rsp);
            send_byte(v.cmd);
            @(negedge clk);
            check("abort_cmd_err", 32'(cmd_err), 1);
            @(negedge clk);
            check("abort_pulse", 32'(cmd_err), 0);
            err_ok = 1'b0;
        end else begin
            send_byte(v.cmd);
            repeat (v.gap) @(posedge clk);
            if (v.cmd == 8'hA5) begin
                send_byte(v.addr);
                repeat (v.gap) @(posedge clk);
                @(negedge clk);
                check("no_early_req", 32'(apb_req), 0);
                req_ok = 1'b1;
                send_byte(v.wdata);
            end else begin
                @(negedge clk);
                check("no_early_req", 32'(apb_req), 0);
                req_ok = 1'b1;
                send_byte(v.addr);
            end
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk);
                check("req_hold", 32'(apb_req), 1);
                check("req_write", 32'(apb_write), 32'(v.exp_write));
                check("req_addr", 32'(apb_addr), 32'(v.addr));
                if (v.exp_write) check("req_wdata", 32'(apb_wdata), 32'(v.wdata));
                check("req_busy", 32'(busy), 1);
                @(posedge clk); #1;
            end
            exp_q.push_back(v.exp_rsp);
            apb_done   = 1'b1;
            apb_rdata  = v.rdata;
            apb_slverr = v.slverr;
            tx_busy    = (v.busy_cyc > 0);
            @(posedge clk); #1;
            apb_done   = 1'b0;
            apb_rdata  = 8'h00;
            apb_slverr = 1'b0;
            req_ok     = 1'b0;
            @(negedge clk);
            check("req_drop", 32'(apb_req), 0);
            if (v.busy_cyc == 0) begin
                check("tx_latency", 32'(tx_valid), 1);
            end else begin
                check("tx_held", 32'(tx_valid), 0);
                for (int i = 1; i < v.busy_cyc; i++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    check("tx_held", 32'(tx_valid), 0);
                end
                @(posedge clk); #1;
                tx_busy = 1'b0;
                @(negedge clk);
                check("tx_not_early", 32'(tx_valid), 0);
                @(negedge clk);
                check("tx_after_busy", 32'(tx_valid), 1);
                @(negedge clk);
                check("tx_one_cycle", 32'(tx_valid), 0);
            end
        end
        settle("vec");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{8'hA5, 8'h10, 8'h3C, 8'h00, 1'b0,  0, 3,  0, 1'b1, 1'b1, 8'h4B};
        vecs[1] = '{8'h5A, 8'h22, 8'h00, 8'h99, 1'b0,  0, 2, 20, 1'b1, 1'b0, 8'h99};
        vecs[2] = '{8'hA5, 8'h01, 8'hFF, 8'h00, 1'b1,  0, 1,  0, 1'b1, 1'b1, 8'h4E};
        vecs[3] = '{8'h77, 8'h00, 8'h00, 8'h00, 1'b0,  0, 0,  0, 1'b0, 1'b0, 8'h4E};
        vecs[4] = '{8'h5A, 8'h80, 8'h00, 8'h5A, 1'b1,  0, 1,  3, 1'b1, 1'b0, 8'h4E};
        vecs[5] = '{8'hA5, 8'hFF, 8'h00, 8'h00, 1'b0, 60, 5,  0, 1'b1, 1'b1, 8'h4B};
        vecs[6] = '{8'h5A, 8'h00, 8'h00, 8'hFF, 1'b0,  0, 1,  0, 1'b1, 1'b0, 8'hFF};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0,  0, 0,  0, 1'b0, 1'b0, 8'h4E};

        rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; frame_err = 1'b0;
        apb_done = 1'b0; apb_rdata = 8'h00; apb_slverr = 1'b0; tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_apb_req", 32'(apb_req), 0);
        check("rst_apb_write", 32'(apb_write), 0);
        check("rst_apb_addr", 32'(apb_addr), 0);
        check("rst_apb_wdata", 32'(apb_wdata), 0);
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_cmd_err", 32'(cmd_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(fsm_state), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // frame_err in IDLE is ignored
        @(posedge clk); #1;
        frame_err = 1'b1;
        @(posedge clk); #1;
        frame_err = 1'b0;
        @(negedge clk);
        check("idle_frame_err", 32'(busy), 0);

        // frame_err alongside rx_valid in GET_ADDR aborts and drops the byte
        send_byte(8'hA5);
        err_ok = 1'b1;
        if (NAK_EN) exp_q.push_back(8'h4E);
        @(posedge clk); #1;
        rx_data = 8'h10; rx_valid = 1'b1; frame_err = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_err = 1'b0;
        @(negedge clk);
        check("ferr_cmd_err", 32'(cmd_err), 1);
        check("ferr_addr_kept", 32'(apb_addr), 32'(8'h00));
        @(negedge clk);
        err_ok = 1'b0;
        settle("ferr");

        // Inter-byte timeout
        err_ok = 1'b1;
        if (NAK_EN) exp_q.push_back(8'h4E);
        send_byte(8'hA5);
        k = 0;
        @(negedge clk);
        while (!cmd_err && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 32'(k), 32'(TMO));
        @(negedge clk);
        err_ok = 1'b0;
        settle("timeout");

        // Reset during WAIT_DONE; stray bytes while busy are dropped
        send_byte(8'h5A);
        req_ok = 1'b1;
        send_byte(8'h33);
        @(negedge clk);
        check("rst_seq_req", 32'(apb_req), 1);
        @(posedge clk); #1;
        rx_data = 8'h77; rx_valid = 1'b1; frame_err = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; frame_err = 1'b0;
        @(negedge clk);
        check("stray_dropped_req", 32'(apb_req), 1);
        check("stray_dropped_state", 32'(fsm_state), 4);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_req", 32'(apb_req), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_tx", 32'(tx_valid), 0);
        check("async_rst_addr", 32'(apb_addr), 0);
        req_ok = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        apb_done = 1'b1; apb_rdata = 8'hEE;
        @(posedge clk); #1;
        apb_done = 1'b0; apb_rdata = 8'h00;
        @(negedge clk);
        check("stale_done_state", 32'(fsm_state), 0);
        settle("stale_done");
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
